video_timing_gen: RTL

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_if.sv | 26 ++
 rtl/video_timing_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/video_timing_if.sv
// Video timing bundle: run request into the generator; pixel strobe, syncs, blank and raster coordinates out.
interface video_timing_if #(
   parameter int CW = 11
);
   logic          enable;
   logic          pix_en;
   logic          hs;
   logic          vs;
   logic          blank;
   logic          sync;
   logic [CW-1:0] draw_x;
   logic [CW-1:0] draw_y;
   logic          line_start;
   logic          frame_start;
   logic          running;

   modport master (
      input  enable,
      output pix_en, hs, vs, blank, sync, draw_x, draw_y, line_start, frame_start, running
   );

   modport slave (
      output enable,
      input  pix_en, hs, vs, blank, sync, draw_x, draw_y, line_start, frame_start, running
   );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: a free-running CLK divider yields pix_en; FSM, counters and syncs advance on pix_en.
// hs/vs/blank are registered from next-count values so they share draw_x/draw_y timing; no backpressure.
module video_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CLK_DIV  = 2,
   parameter int CW       = 11
) (
   input  logic           CLK,
   input  logic           RESET,
   video_timing_if.master vif
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (CLK_DIV < 1 || H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_params
      $error("video_timing_gen: CLK_DIV must be >= 1 and H/V totals must fit in CW bits");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [DW-1:0] div_q;
   logic          div_last;
   logic          pix_en;
   logic [CW-1:0] x_q;
   logic [CW-1:0] y_q;
   logic [CW-1:0] x_d;
   logic [CW-1:0] y_d;
   logic          x_last;
   logic          y_last;
   logic          hs_q;
   logic          vs_q;
   logic          blank_q;
   logic          hs_d;
   logic          vs_d;
   logic          blank_d;
   logic          run_d;
   logic          running;

   // pix_en is gated by RESET so the CLK_DIV=1 case also reads 0 while reset is held.
   assign div_last = (div_q == DW'(CLK_DIV - 1));
   assign pix_en   = div_last & ~RESET;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         div_q <= '0;
      end else if (div_last) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   assign x_last = (x_q == CW'(H_TOTAL - 1));
   assign y_last = (y_q == CW'(V_TOTAL - 1));

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      unique case (state_q)
         IDLE: begin
            if (vif.enable) begin
               state_d = RUN;
            end
         end
         RUN, DRAIN: begin
            if (x_last && y_last && !vif.enable) begin
               state_d = IDLE;
               x_d     = '0;
               y_d     = '0;
            end else begin
               state_d = vif.enable ? RUN : DRAIN;
               if (x_last) begin
                  x_d = '0;
                  y_d = y_last ? '0 : y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
         end
      endcase

      // Decode from the next position so the registered syncs line up with the registered counters.
      run_d   = (state_d != IDLE);
      hs_d    = (run_d && x_d >= CW'(HS_START) && x_d < CW'(HS_END)) ? HS_POL : ~HS_POL;
      vs_d    = (run_d && y_d >= CW'(VS_START) && y_d < CW'(VS_END)) ? VS_POL : ~VS_POL;
      blank_d = run_d && (x_d < CW'(H_ACTIVE)) && (y_d < CW'(V_ACTIVE));
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
      end else if (pix_en) begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         x_q     <= '0;
         y_q     <= '0;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         blank_q <= 1'b0;
      end else if (pix_en) begin
         x_q     <= x_d;
         y_q     <= y_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         blank_q <= blank_d;
      end
   end

   assign running         = (state_q != IDLE);
   assign vif.pix_en      = pix_en;
   assign vif.hs          = hs_q;
   assign vif.vs          = vs_q;
   assign vif.blank       = blank_q;
   assign vif.sync        = 1'b0;
   assign vif.draw_x      = x_q;
   assign vif.draw_y      = y_q;
   assign vif.running     = running;
   assign vif.line_start  = running & pix_en & (x_q == '0);
   assign vif.frame_start = running & pix_en & (x_q == '0) & (y_q == '0);

endmodule
